cv32e40s_rvfi_obi_pairing: RTL and testbench



---
 rtl/cv32e40s_rvfi_obi_pairing.sv | 161 ++++++++++++++++
 tb/tb_cv32e40s_rvfi_obi_pairing.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_rvfi_obi_pairing.sv
// Pairs granted OBI fetch requests with their in-order responses and streams {req, resp} records.
// Optional CV32E40S_RVFI_OBI_CHK_EN: sticky err_o on illegal events plus simulation assertions.
module cv32e40s_rvfi_obi_pairing #(
    parameter int DEPTH  = 2,
    parameter int REQ_W  = 34,
    parameter int RESP_W = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     obi_req_i,
    input  logic                     obi_gnt_i,
    input  logic [REQ_W-1:0]         obi_req_payload_i,
    input  logic                     obi_rvalid_i,
    input  logic [RESP_W-1:0]        obi_resp_payload_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [REQ_W-1:0]         out_req_payload_o,
    output logic [RESP_W-1:0]        out_resp_payload_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [REQ_W-1:0]  req_q  [DEPTH];
    logic [RESP_W-1:0] resp_q [DEPTH];
    logic [DEPTH-1:0]  done_q;
    logic [PW-1:0]     wr_ptr_q, rsp_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     await_q, await_d;
    logic              alloc_s, cmpl_s, pop_s;
    logic              bad_gnt_s, bad_rvalid_s;

    // Event decode uses registered counts only, so the inputs never reach out_* combinationally.
    always_comb begin
        bad_gnt_s    = obi_req_i & obi_gnt_i & (count_q == FULL_CNT);
        bad_rvalid_s = obi_rvalid_i & (await_q == {CW{1'b0}});
        alloc_s      = obi_req_i & obi_gnt_i & (count_q != FULL_CNT);
        cmpl_s       = obi_rvalid_i & (await_q != {CW{1'b0}});
        pop_s        = out_valid_o & out_ready_i;
    end

    // Next values of the allocated and awaiting-response counters.
    always_comb begin
        count_d = count_q;
        await_d = await_q;
        if (alloc_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (!alloc_s && pop_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
        if (alloc_s && !cmpl_s) begin
            await_d = await_q + CNT_ONE;
        end else if (!alloc_s && cmpl_s) begin
            await_d = await_q - CNT_ONE;
        end else begin
            await_d = await_q;
        end
    end

    // Pointers and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= {PW{1'b0}};
            rsp_ptr_q <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            await_q   <= {CW{1'b0}};
        end else begin
            if (alloc_s) wr_ptr_q  <= wr_ptr_q + PTR_ONE;
            if (cmpl_s)  rsp_ptr_q <= rsp_ptr_q + PTR_ONE;
            if (pop_s)   rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            await_q <= await_d;
        end
    end

    // Entry storage; the three write indices never collide while their events are legal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                req_q[i]  <= {REQ_W{1'b0}};
                resp_q[i] <= {RESP_W{1'b0}};
            end
            done_q <= {DEPTH{1'b0}};
        end else begin
            if (alloc_s) begin
                req_q[wr_ptr_q]  <= obi_req_payload_i;
                done_q[wr_ptr_q] <= 1'b0;
            end
            if (cmpl_s) begin
                resp_q[rsp_ptr_q] <= obi_resp_payload_i;
                done_q[rsp_ptr_q] <= 1'b1;
            end
            if (pop_s) begin
                done_q[rd_ptr_q] <= 1'b0;
            end
        end
    end

    // Head view is a pure read of registered storage.
    always_comb begin
        out_valid_o        = done_q[rd_ptr_q] & (count_q != {CW{1'b0}});
        out_req_payload_o  = req_q[rd_ptr_q];
        out_resp_payload_o = resp_q[rd_ptr_q];
        count_o            = count_q;
    end

`ifdef CV32E40S_RVFI_OBI_CHK_EN
    logic err_q;

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bad_gnt_s || bad_rvalid_s) begin
            err_q <= 1'b1;
        end
    end
    assign err_o = err_q;

    cv32e40s_rvfi_obi_pairing_chk #(.REQ_W(REQ_W), .RESP_W(RESP_W)) u_chk (
        .clk_i        (clk),
        .rst_i        (rst),
        .bad_gnt_i    (bad_gnt_s),
        .bad_rvalid_i (bad_rvalid_s),
        .valid_i      (out_valid_o),
        .ready_i      (out_ready_i),
        .req_i        (out_req_payload_o),
        .resp_i       (out_resp_payload_o)
    );
`else
    assign err_o = 1'b0;
`endif
endmodule

`ifdef CV32E40S_RVFI_OBI_CHK_EN
module cv32e40s_rvfi_obi_pairing_chk #(
    parameter int REQ_W  = 34,
    parameter int RESP_W = 34
) (
    input logic              clk_i,
    input logic              rst_i,
    input logic              bad_gnt_i,
    input logic              bad_rvalid_i,
    input logic              valid_i,
    input logic              ready_i,
    input logic [REQ_W-1:0]  req_i,
    input logic [RESP_W-1:0] resp_i
);
    a_no_full_gnt: assert property (@(posedge clk_i) disable iff (rst_i) !bad_gnt_i);
    a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (rst_i) !bad_rvalid_i);
    a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_i && !ready_i) |=> (valid_i && $stable(req_i) && $stable(resp_i)));
endmodule
`endif

// File: tb/tb_cv32e40s_rvfi_obi_pairing.sv
// Randomized bench for cv32e40s_rvfi_obi_pairing against a queue-based transaction model.
module tb_cv32e40s_rvfi_obi_pairing;
    localparam int DEPTH = 4;
    localparam int W     = 34;

    logic          clk = 1'b0;
    logic          rst;
    logic          obi_req_i, obi_gnt_i, obi_rvalid_i, out_ready_i;
    logic [W-1:0]  obi_req_payload_i, obi_resp_payload_i;
    logic          out_valid_o, err_o;
    logic [W-1:0]  out_req_payload_o, out_resp_payload_o;
    logic [2:0]    count_o;

    int n_cmp = 0;
    int n_err = 0;

    // Model: completed records in order, then requests still awaiting a response.
    logic [W-1:0] done_req[$];
    logic [W-1:0] done_rsp[$];
    logic [W-1:0] pend_req[$];
    logic         m_err = 1'b0;

    always #5 clk = ~clk;

    cv32e40s_rvfi_obi_pairing #(.DEPTH(DEPTH), .REQ_W(W), .RESP_W(W)) dut (
        .clk                (clk),
        .rst                (rst),
        .obi_req_i          (obi_req_i),
        .obi_gnt_i          (obi_gnt_i),
        .obi_req_payload_i  (obi_req_payload_i),
        .obi_rvalid_i       (obi_rvalid_i),
        .obi_resp_payload_i (obi_resp_payload_i),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .out_req_payload_o  (out_req_payload_o),
        .out_resp_payload_o (out_resp_payload_o),
        .count_o            (count_o),
        .err_o              (err_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int total;
        total = done_req.size() + pend_req.size();
        check_eq("valid", {63'd0, out_valid_o}, {63'd0, done_req.size() != 0});
        check_eq("count", {61'd0, count_o}, 64'(total));
        check_eq("err", {63'd0, err_o}, {63'd0, m_err});
        if (done_req.size() != 0) begin
            check_eq("head_req", {30'd0, out_req_payload_o}, {30'd0, done_req[0]});
            check_eq("head_resp", {30'd0, out_resp_payload_o}, {30'd0, done_rsp[0]});
        end
    endtask

    task automatic check_reset_state();
        check_eq("rst_valid", {63'd0, out_valid_o}, 64'd0);
        check_eq("rst_count", {61'd0, count_o}, 64'd0);
        check_eq("rst_err", {63'd0, err_o}, 64'd0);
        check_eq("rst_req", {30'd0, out_req_payload_o}, 64'd0);
        check_eq("rst_resp", {30'd0, out_resp_payload_o}, 64'd0);
    endtask

    // One cycle: drive at negedge, clock edge, update model, check at next negedge.
    task automatic step(input logic r, input logic g, input logic [W-1:0] rp,
                        input logic v, input logic [W-1:0] sp, input logic rdy);
        bit do_alloc, do_cmpl, do_pop, bad_g, bad_v;
        logic [W-1:0] creq;
        obi_req_i = r; obi_gnt_i = g; obi_req_payload_i = rp;
        obi_rvalid_i = v; obi_resp_payload_i = sp; out_ready_i = rdy;
        do_pop   = (done_req.size() != 0) && rdy;
        do_cmpl  = v && (pend_req.size() != 0);
        do_alloc = r && g && (done_req.size() + pend_req.size() < DEPTH);
        bad_g    = r && g && !do_alloc;
        bad_v    = v && !do_cmpl;
        @(posedge clk);
        if (do_pop) begin
            void'(done_req.pop_front());
            void'(done_rsp.pop_front());
        end
        if (do_cmpl) begin
            creq = pend_req.pop_front();
            done_req.push_back(creq);
            done_rsp.push_back(sp);
        end
        if (do_alloc) pend_req.push_back(rp);
`ifdef CV32E40S_RVFI_OBI_CHK_EN
        if (bad_g || bad_v) m_err = 1'b1;
`else
        if (bad_g || bad_v) m_err = 1'b0;
`endif
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic clear_model();
        done_req.delete();
        done_rsp.delete();
        pend_req.delete();
        m_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        obi_req_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; out_ready_i = 1'b0;
        obi_req_payload_i = '0; obi_resp_payload_i = '0;
        repeat (2) @(negedge clk);
        check_reset_state();
        rst = 1'b0;

        // Single transaction
        step(1'b1, 1'b1, 34'h100, 1'b0, '0, 1'b1);
        idle(1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 34'hAA, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Pipelined fill with stalled consumer, then full drop
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 34'(i * 4), 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, 34'(32'hA0 + i), 1'b0);
        step(1'b1, 1'b1, 34'h200, 1'b0, '0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Spurious response on empty tracker
        step(1'b0, 1'b0, '0, 1'b1, 34'h55, 1'b1);
        idle(1'b1);

        // Simultaneous allocate + pop + complete
        step(1'b1, 1'b1, 34'h10, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 34'h20, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 34'hB1, 1'b0);
        step(1'b1, 1'b1, 34'h300, 1'b1, 34'hB2, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 34'hB3, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 34'(32'h400 + i), 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 34'hC0, 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_state();
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 34'h3_1234_5678, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 34'h2_8765_4321, 1'b0);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 34'({$urandom(), $urandom()}),
                 $urandom_range(0, 2) != 0,
                 34'({$urandom(), $urandom()}),
                 $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
